fire_seq_ctrl: RTL and testbench
================================

Name: fire_seq_ctrl

Overview:
- Scheduler for the fire expand/max datapath.
- Holds a small table of per-fire configurations written by the host. On `run_i` it walks the table.
- For each entry it drives the expand config bus, pulses `start_o`, waits for the datapath's fire-end flag, drains, then moves to the next entry.
- Signals completion to the host. Sits between the host/config interface and the expand config/control block.

Parameters:
- MAX_FIRES, 8, number of table entries (power of 2); IDXW = log2(MAX_FIRES).
- DRAIN_CYCLES, 4, idle cycles after fire end before the next start (output pipeline flush).
- WDOG_W, 20, width of per-fire watchdog counter; timeout at all-ones.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- cfg_wr_en_i  in  1  table write strobe
- cfg_wr_addr_i  in  IDXW  table entry index
- cfg_wr_data_i  in  25  {max_en[24], addr_limit[23:13], ker_depth[12:7], layer_dim[6:0]}
- num_fires_i  in  IDXW+1  fires to run, 1..MAX_FIRES; sampled at run
- run_i  in  1  start-sequence pulse
- abort_i  in  1  abort-sequence pulse
- fire_end_flag_i  in  1  level from datapath; set at fire end, cleared by `start_o`
- start_o  out  1  one-cycle start to datapath
- max_en_o  out  1  config field
- one_exp_layer_addr_limit_o  out  11  config field, (dim*exp_kernels/4)-1
- exp_ker_depth_o  out  6  config field, depth-1
- layer_dimension_o  out  7  config field, dim-1
- fire_idx_o  out  IDXW  entry currently executing
- busy_o  out  1  high from accepted run until DONE
- done_o  out  1  one-cycle completion pulse
- err_o  out  2  sticky error: [0] bad config/run, [1] watchdog timeout; cleared on accepted run

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Table contents 0. Watchdog, drain and index counters 0.
- FSM states: IDLE, LOAD, START, RUN, DRAIN, DONE.
- IDLE:
  - `run_i` with 1 <= num_fires_i <= MAX_FIRES → LOAD. Latch num_fires, fire_idx_o = 0, err_o = 0, busy_o = 1.
  - Otherwise a `run_i` only sets err_o[0] and the FSM stays IDLE.
- LOAD: register table[fire_idx] onto the config outputs → START. Config outputs stay stable until the next LOAD.
- START: `start_o` = 1 for exactly one cycle; clear watchdog → RUN.
- Latency: run_i at cycle N gives start_o at cycle N+2.
- RUN:
  - `fire_end_flag_i` = 1 → DRAIN.
  - The flag is ignored in the first RUN cycle (guard against stale level).
  - Watchdog increments each cycle. At all-ones: set err_o[1] → DONE.
- DRAIN:
  - Count DRAIN_CYCLES cycles.
  - If fire_idx == num_fires-1 → DONE.
  - Otherwise fire_idx_o + 1 → LOAD.
- DONE: `done_o` = 1 for one cycle, busy_o = 0 → IDLE.
- `abort_i` in any non-IDLE state → DONE next cycle. done_o still pulses. `start_o` is never issued after abort. Abort in IDLE is ignored.
- `run_i` while busy: ignored, sets err_o[0].
- Table writes:
  - Accepted any time except when `cfg_wr_addr_i` equals the fire_idx currently in LOAD; such a collision is dropped and sets err_o[0].
  - Writes to other entries while busy take effect for that entry's later LOAD.
- `run_i` and `abort_i` in the same IDLE cycle: run wins.
- `fire_end_flag_i` and `abort_i` in the same cycle: abort wins.
- fire_idx never wraps. num_fires = MAX_FIRES runs entries 0..MAX_FIRES-1.

Decomposition:
- Package fire_seq_pkg: state encoding localparams; config field bit positions and widths (11/6/7/1); CFG_W = 25.
- Sub-module fire_cfg_regfile: MAX_FIRES x CFG_W register array, synchronous write, registered read at LOAD.

Test Plan:
- Write entry0 = {1, 11'd383, 6'd15, 7'd54}; num_fires = 1; run; assert fire_end 40 cycles after start_o → start_o at run+2 with fields 383/15/54/max_en = 1; done_o pulses 1 + DRAIN_CYCLES + 1 cycles after fire_end; busy_o falls.
- 3 entries with distinct values, num_fires = 3 → exactly 3 start_o pulses; fire_idx_o = 0, 1, 2; each config matches its entry; start spacing ≥ DRAIN_CYCLES + 2 after each fire_end.
- num_fires = 0, then run → err_o = 2'b01, no start_o, busy_o stays 0. Then a valid run → err_o cleared.
- No fire_end with WDOG_W = 6 → err_o[1] set after 63 RUN cycles, done_o pulses, FSM returns to IDLE.
- abort_i during RUN of fire 1 of 3 → done_o next cycle, no further start_o; a subsequent run restarts from index 0.
- rst_n_i low mid-RUN, asynchronously → all outputs 0 immediately; after release a run behaves as a fresh sequence with a zeroed table.

Source files
------------

// File: rtl/fire_seq_pkg.sv
// Shared types for the fire sequencer: FSM states, config field layout and the packed config record.
package fire_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int CFG_W     = 25;
  localparam int LDIM_LSB  = 0;
  localparam int LDIM_W    = 7;
  localparam int KDEP_LSB  = 7;
  localparam int KDEP_W    = 6;
  localparam int ALIM_LSB  = 13;
  localparam int ALIM_W    = 11;
  localparam int MAXEN_BIT = 24;

  typedef struct packed {
    logic              max_en;
    logic [ALIM_W-1:0] addr_limit;
    logic [KDEP_W-1:0] ker_depth;
    logic [LDIM_W-1:0] layer_dim;
  } fire_cfg_t;

  function automatic fire_cfg_t unpack_cfg(input logic [CFG_W-1:0] raw);
    fire_cfg_t c;
    c.max_en     = raw[MAXEN_BIT];
    c.addr_limit = raw[ALIM_LSB +: ALIM_W];
    c.ker_depth  = raw[KDEP_LSB +: KDEP_W];
    c.layer_dim  = raw[LDIM_LSB +: LDIM_W];
    return c;
  endfunction

endpackage

// File: rtl/fire_seq_ctrl_regfile.sv
// Per-fire config table: synchronous write, registered read; read data holds until the next read.
// One-cycle read latency; writes are never stalled (the caller filters colliding writes).
module fire_cfg_regfile
  import fire_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  fire_cfg_t     i_wr_dat,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output fire_cfg_t     o_rd_dat
);

  fire_cfg_t r_mem [DEPTH];
  fire_cfg_t r_rd_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/fire_seq_ctrl.sv
// Walks the host-written fire table, driving config and a start pulse per fire, then drains.
// run_i to start_o is two cycles; pacing comes only from fire_end_flag_i, the drain window and the watchdog.
module fire_seq_ctrl
  import fire_seq_pkg::*;
#(
  parameter int MAX_FIRES    = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter int WDOG_W       = 20,
  localparam int IDXW        = $clog2(MAX_FIRES)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_wr_en_i,
  input  logic [IDXW-1:0]  cfg_wr_addr_i,
  input  logic [CFG_W-1:0] cfg_wr_data_i,
  input  logic [IDXW:0]    num_fires_i,
  input  logic             run_i,
  input  logic             abort_i,
  input  logic             fire_end_flag_i,
  output logic             start_o,
  output logic             max_en_o,
  output logic [10:0]      one_exp_layer_addr_limit_o,
  output logic [5:0]       exp_ker_depth_o,
  output logic [6:0]       layer_dimension_o,
  output logic [IDXW-1:0]  fire_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o
);

  localparam int DRW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST  = {{(WDOG_W-1){1'b1}}, 1'b0};
  localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);
  localparam logic [DRW-1:0]    DRAIN_LAST = DRW'(DRAIN_CYCLES);
  localparam logic [DRW-1:0]    DRAIN_ONE  = DRW'(1);
  localparam logic [IDXW:0]     NUM_MAX    = (IDXW+1)'(MAX_FIRES);
  localparam logic [IDXW:0]     NUM_ONE    = (IDXW+1)'(1);
  localparam logic [IDXW-1:0]   IDX_ONE    = IDXW'(1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDXW-1:0]   r_fire_idx;
  logic [IDXW:0]     r_num_fires;
  logic [WDOG_W-1:0] r_wdog;
  logic [DRW-1:0]    r_drain;
  logic [1:0]        r_err;
  logic              w_num_ok;
  logic              w_accept_run;
  logic              w_abort;
  logic              w_timeout;
  logic              w_last_fire;
  logic              w_wr_collide;
  logic              w_wr_en;
  logic              w_rd_en;
  fire_cfg_t         w_wr_dat;
  fire_cfg_t         w_cfg;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_num_ok     = (num_fires_i != '0) && (num_fires_i <= NUM_MAX);
  assign w_last_fire  = ({1'b0, r_fire_idx} == (r_num_fires - NUM_ONE));
  assign w_abort      = abort_i && (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_wr_collide = cfg_wr_en_i && (r_state == ST_LOAD) && (cfg_wr_addr_i == r_fire_idx);
  assign w_wr_en      = cfg_wr_en_i && !w_wr_collide;
  assign w_wr_dat     = unpack_cfg(cfg_wr_data_i);
  assign w_rd_en      = (r_state == ST_LOAD);

  always_comb begin
    w_state_nxt  = r_state;
    w_accept_run = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run_i && w_num_ok) begin
          w_accept_run = 1'b1;
          w_state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN: begin
        // A zero watchdog marks the first RUN cycle, where the flag may still be stale.
        if (fire_end_flag_i && (r_wdog != '0)) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_state_nxt = w_last_fire ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fire_idx  <= '0;
      r_num_fires <= '0;
    end else if (w_accept_run) begin
      r_fire_idx  <= '0;
      r_num_fires <= num_fires_i;
    end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_LOAD)) begin
      r_fire_idx  <= r_fire_idx + IDX_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wdog  <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == ST_START) begin
        r_wdog <= '0;
      end else if (r_state == ST_RUN) begin
        r_wdog <= r_wdog + WDOG_ONE;
      end
      r_drain <= (r_state == ST_DRAIN) ? (r_drain + DRAIN_ONE) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 2'b00;
    end else if (w_accept_run) begin
      r_err <= 2'b00;
    end else begin
      if ((run_i && !w_accept_run) || w_wr_collide) begin
        r_err[0] <= 1'b1;
      end
      if (w_timeout && !w_abort) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  fire_cfg_regfile #(
    .DEPTH (MAX_FIRES)
  ) u_cfg_regfile (
    .i_clk     (clk_i),
    .i_rst_n   (w_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (cfg_wr_addr_i),
    .i_wr_dat  (w_wr_dat),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_fire_idx),
    .o_rd_dat  (w_cfg)
  );

  assign start_o                    = (r_state == ST_START);
  assign done_o                     = (r_state == ST_DONE);
  assign busy_o                     = (r_state == ST_LOAD) || (r_state == ST_START) ||
                                      (r_state == ST_RUN)  || (r_state == ST_DRAIN);
  assign err_o                      = r_err;
  assign fire_idx_o                 = r_fire_idx;
  assign max_en_o                   = w_cfg.max_en;
  assign one_exp_layer_addr_limit_o = w_cfg.addr_limit;
  assign exp_ker_depth_o            = w_cfg.ker_depth;
  assign layer_dimension_o          = w_cfg.layer_dim;

endmodule

// File: tb/tb_fire_seq_ctrl.sv
// Directed + randomized bench for fire_seq_ctrl with a timeline-level reference model.
module tb_fire_seq_ctrl;

  localparam int MAXF = 8;
  localparam int DRN  = 4;
  localparam int WDW  = 6;
  localparam int IDXW = 3;

  logic            clk_i           = 1'b0;
  logic            rst_n_i         = 1'b0;
  logic            cfg_wr_en_i     = 1'b0;
  logic [IDXW-1:0] cfg_wr_addr_i   = '0;
  logic [24:0]     cfg_wr_data_i   = '0;
  logic [IDXW:0]   num_fires_i     = '0;
  logic            run_i           = 1'b0;
  logic            abort_i         = 1'b0;
  logic            fire_end_flag_i = 1'b0;
  logic            start_o;
  logic            max_en_o;
  logic [10:0]     one_exp_layer_addr_limit_o;
  logic [5:0]      exp_ker_depth_o;
  logic [6:0]      layer_dimension_o;
  logic [IDXW-1:0] fire_idx_o;
  logic            busy_o;
  logic            done_o;
  logic [1:0]      err_o;

  fire_seq_ctrl #(.MAX_FIRES(MAXF), .DRAIN_CYCLES(DRN), .WDOG_W(WDW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_wr_en_i(cfg_wr_en_i), .cfg_wr_addr_i(cfg_wr_addr_i), .cfg_wr_data_i(cfg_wr_data_i),
    .num_fires_i(num_fires_i), .run_i(run_i), .abort_i(abort_i), .fire_end_flag_i(fire_end_flag_i),
    .start_o(start_o), .max_en_o(max_en_o), .one_exp_layer_addr_limit_o(one_exp_layer_addr_limit_o),
    .exp_ker_depth_o(exp_ker_depth_o), .layer_dimension_o(layer_dimension_o),
    .fire_idx_o(fire_idx_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [24:0] tb_tab [MAXF];
  int fe_delay[$];
  int ev_start_cyc[$];
  int ev_start_idx[$];
  logic [24:0] ev_start_cfg[$];
  int ev_fe_cyc[$];
  int ev_done_cyc[$];
  int dp_cnt = 0;
  int dp_clr = 0;

  always @(posedge clk_i) cyc++;

  // Datapath stand-in: raises the fire-end level a set delay after start_o, and drops it
  // two cycles after the next start_o so the first RUN cycle sees a stale level.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      dp_cnt = 0;
      dp_clr = 0;
      fire_end_flag_i = 1'b0;
    end else begin
      if (dp_clr > 0) begin
        dp_clr--;
        if (dp_clr == 0) fire_end_flag_i = 1'b0;
      end
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          fire_end_flag_i = 1'b1;
          ev_fe_cyc.push_back(cyc);
        end
      end
      if (start_o) begin
        ev_start_cyc.push_back(cyc);
        ev_start_idx.push_back(int'(fire_idx_o));
        ev_start_cfg.push_back({max_en_o, one_exp_layer_addr_limit_o, exp_ker_depth_o, layer_dimension_o});
        dp_clr = 2;
        dp_cnt = (fe_delay.size() > 0) ? fe_delay.pop_front() : 0;
      end
      if (done_o) ev_done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int a, input logic [24:0] d, input bit keep);
    cfg_wr_en_i   = 1'b1;
    cfg_wr_addr_i = IDXW'(a);
    cfg_wr_data_i = d;
    tick();
    cfg_wr_en_i   = 1'b0;
    if (keep) tb_tab[a] = d;
  endtask

  task automatic clr_ev();
    ev_start_cyc.delete();
    ev_start_idx.delete();
    ev_start_cfg.delete();
    ev_fe_cyc.delete();
    ev_done_cyc.delete();
  endtask

  task automatic pulse_run(input int n, output int r);
    num_fires_i = (IDXW+1)'(n);
    run_i = 1'b1;
    r = cyc;
    tick();
    run_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (ev_done_cyc.size() == 0 && t < budget) begin
      tick();
      t++;
    end
    tick();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctl"}, 32'({start_o, busy_o, done_o, err_o}), 32'd0);
    check({tag, "_cfg"}, 32'({max_en_o, one_exp_layer_addr_limit_o, exp_ker_depth_o, layer_dimension_o}), 32'd0);
    check({tag, "_idx"}, 32'(fire_idx_o), 32'd0);
  endtask

  // Expected timeline: first start two cycles after run, one start per fire in index order
  // carrying that entry, at least DRN+2 cycles between a fire end and the next start,
  // and a single done pulse DRN+2 cycles after the last fire end.
  task automatic verify_seq(input int r, input int n, input logic [1:0] exp_err);
    check("start_count", 32'(ev_start_cyc.size()), 32'(n));
    check("done_count", 32'(ev_done_cyc.size()), 32'd1);
    for (int k = 0; k < n && k < ev_start_cyc.size(); k++) begin
      check("fire_idx", 32'(ev_start_idx[k]), 32'(k));
      check("cfg", 32'(ev_start_cfg[k]), 32'(tb_tab[k]));
      if (k == 0) check("start_lat", 32'(ev_start_cyc[0]), 32'(r + 2));
      else if (k - 1 < ev_fe_cyc.size())
        check("start_gap_ok", 32'((ev_start_cyc[k] - ev_fe_cyc[k-1]) >= DRN + 2), 32'd1);
    end
    if (ev_done_cyc.size() > 0 && ev_fe_cyc.size() >= n)
      check("done_lat", 32'(ev_done_cyc[0]), 32'(ev_fe_cyc[n-1] + DRN + 2));
    check("busy_end", 32'(busy_o), 32'd0);
    check("err_end", 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    int r;
    int a;
    int t;
    logic [24:0] v;
    for (int i = 0; i < MAXF; i++) tb_tab[i] = '0;

    // Reset state, held and after release.
    repeat (3) tick();
    check_idle_zero("rst_hold");
    rst_n_i = 1'b1;
    repeat (4) tick();
    check_idle_zero("rst_rel");

    // Single fire, fixed entry, fire end 40 cycles after start.
    wr(0, {1'b1, 11'd383, 6'd15, 7'd54}, 1'b1);
    clr_ev();
    fe_delay.push_back(40);
    pulse_run(1, r);
    check("busy_after_run", 32'(busy_o), 32'd1);
    wait_done(200);
    verify_seq(r, 1, 2'b00);

    // Three random entries.
    for (int k = 0; k < 3; k++) wr(k, 25'($urandom), 1'b1);
    clr_ev();
    for (int k = 0; k < 3; k++) fe_delay.push_back(int'($urandom_range(3, 30)));
    pulse_run(3, r);
    wait_done(400);
    verify_seq(r, 3, 2'b00);

    // Invalid fire counts, then a valid run clears the error.
    clr_ev();
    pulse_run(0, r);
    repeat (3) tick();
    check("bad0_err", 32'(err_o), 32'd1);
    check("bad0_busy", 32'(busy_o), 32'd0);
    pulse_run(MAXF + 1, r);
    repeat (3) tick();
    check("bad9_err", 32'(err_o), 32'd1);
    check("bad_no_start", 32'(ev_start_cyc.size()), 32'd0);
    fe_delay.push_back(5);
    pulse_run(1, r);
    check("err_cleared", 32'(err_o), 32'd0);
    wait_done(200);
    verify_seq(r, 1, 2'b00);

    // Watchdog: no fire end, timeout after 63 RUN cycles.
    clr_ev();
    fe_delay.delete();
    pulse_run(1, r);
    wait_done(200);
    check("wd_starts", 32'(ev_start_cyc.size()), 32'd1);
    if (ev_start_cyc.size() > 0 && ev_done_cyc.size() > 0)
      check("wd_done_lat", 32'(ev_done_cyc[0]), 32'(ev_start_cyc[0] + 64));
    check("wd_err", 32'(err_o), 32'd2);
    check("wd_busy", 32'(busy_o), 32'd0);

    // Abort during RUN of fire 1 of 3; restart goes from index 0.
    for (int k = 0; k < 3; k++) wr(k, 25'($urandom), 1'b1);
    clr_ev();
    fe_delay.push_back(20); fe_delay.push_back(25); fe_delay.push_back(20);
    pulse_run(3, r);
    t = 0;
    while (ev_start_cyc.size() < 2 && t < 200) begin tick(); t++; end
    repeat (5) tick();
    abort_i = 1'b1;
    a = cyc;
    tick();
    abort_i = 1'b0;
    tick();
    check("abort_done_lat", 32'((ev_done_cyc.size() > 0) ? ev_done_cyc[0] : -1), 32'(a + 1));
    repeat (40) tick();
    check("abort_no_start", 32'(ev_start_cyc.size()), 32'd2);
    check("abort_busy", 32'(busy_o), 32'd0);
    fe_delay.delete();
    clr_ev();
    fe_delay.push_back(8);
    pulse_run(1, r);
    wait_done(200);
    verify_seq(r, 1, 2'b00);

    // Write collision in LOAD is dropped; write to a later entry while busy lands; run while busy flags.
    for (int k = 0; k < 3; k++) wr(k, 25'($urandom), 1'b1);
    clr_ev();
    for (int k = 0; k < 3; k++) fe_delay.push_back(int'($urandom_range(3, 15)));
    pulse_run(3, r);
    wr(0, ~tb_tab[0], 1'b0);
    v = 25'($urandom);
    wr(2, v, 1'b1);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    wait_done(400);
    verify_seq(r, 3, 2'b01);

    // Full table, with abort coincident with run in IDLE.
    for (int k = 0; k < MAXF; k++) wr(k, 25'($urandom), 1'b1);
    clr_ev();
    for (int k = 0; k < MAXF; k++) fe_delay.push_back(int'($urandom_range(3, 12)));
    abort_i = 1'b1;
    pulse_run(MAXF, r);
    abort_i = 1'b0;
    wait_done(600);
    verify_seq(r, MAXF, 2'b00);

    // Asynchronous reset mid-RUN, then a fresh sequence sees a zeroed table.
    clr_ev();
    fe_delay.push_back(30); fe_delay.push_back(30);
    pulse_run(2, r);
    t = 0;
    while (ev_start_cyc.size() < 1 && t < 50) begin tick(); t++; end
    repeat (5) tick();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_idle_zero("async_rst");
    repeat (2) tick();
    rst_n_i = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < MAXF; i++) tb_tab[i] = '0;
    fe_delay.delete();
    clr_ev();
    fe_delay.push_back(10);
    pulse_run(1, r);
    wait_done(200);
    verify_seq(r, 1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
